// File: rtl/ab_pulse_sender.sv
// Serialises a parallel word MSB-first onto two pulse lines: '1' bits pulse
// a_out_o, '0' bits pulse b_out_o, each pulse followed by an idle gap.
module ab_pulse_sender #(
  parameter int WIDTH     = 8,
  parameter int LEN_W     = 4,
  parameter int PULSE_LEN = 4,
  parameter int GAP_LEN   = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic [LEN_W-1:0] len_i,
  input  logic             abort_i,
  output logic             a_out_o,
  output logic             b_out_o,
  output logic             ready_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [LEN_W-1:0] bits_left_o
);

  localparam int TMAX = (PULSE_LEN > GAP_LEN) ? PULSE_LEN : GAP_LEN;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam logic [TW-1:0]    P_LOAD  = TW'(PULSE_LEN - 1);
  localparam logic [TW-1:0]    G_LOAD  = TW'(GAP_LEN - 1);
  localparam logic [TW-1:0]    T_ONE   = TW'(1);
  localparam logic [TW-1:0]    T_ZERO  = TW'(0);
  localparam logic [LEN_W-1:0] WIDTH_L = LEN_W'(WIDTH);
  localparam logic [LEN_W-1:0] L_ONE   = LEN_W'(1);
  localparam logic [LEN_W-1:0] L_ZERO  = LEN_W'(0);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PULSE = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   sh_q, sh_d;
  logic [TW-1:0]      timer_q, timer_d;
  logic [LEN_W-1:0]   bits_q, bits_d;
  logic               a_q, a_d;
  logic               b_q, b_d;
  logic               done_q, done_d;
  logic [LEN_W-1:0]   len_clamp_s;

  // The current bit always sits in the shift register MSB; the word is
  // left-aligned at load so bit len-1 goes out first.
  always_comb begin
    state_d     = state_q;
    sh_d        = sh_q;
    timer_d     = timer_q;
    bits_d      = bits_q;
    a_d         = a_q;
    b_d         = b_q;
    done_d      = 1'b0;
    len_clamp_s = (len_i > WIDTH_L) ? WIDTH_L : len_i;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          if (len_clamp_s != L_ZERO) begin
            sh_d    = data_i << (WIDTH_L - len_clamp_s);
            bits_d  = len_clamp_s;
            timer_d = P_LOAD;
            state_d = S_PULSE;
            a_d     = sh_d[WIDTH-1];
            b_d     = ~sh_d[WIDTH-1];
          end else begin
            done_d  = 1'b1;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_PULSE: begin
        if (abort_i) begin
          state_d = S_IDLE;
          sh_d    = '0;
          timer_d = T_ZERO;
          bits_d  = L_ZERO;
          a_d     = 1'b0;
          b_d     = 1'b0;
        end else if (timer_q == T_ZERO) begin
          state_d = S_GAP;
          timer_d = G_LOAD;
          a_d     = 1'b0;
          b_d     = 1'b0;
        end else begin
          timer_d = timer_q - T_ONE;
        end
      end
      S_GAP: begin
        if (abort_i) begin
          state_d = S_IDLE;
          sh_d    = '0;
          timer_d = T_ZERO;
          bits_d  = L_ZERO;
        end else if (timer_q == T_ZERO) begin
          if (bits_q > L_ONE) begin
            bits_d  = bits_q - L_ONE;
            sh_d    = sh_q << 1;
            timer_d = P_LOAD;
            state_d = S_PULSE;
            a_d     = sh_d[WIDTH-1];
            b_d     = ~sh_d[WIDTH-1];
          end else begin
            state_d = S_IDLE;
            bits_d  = L_ZERO;
            sh_d    = '0;
            done_d  = 1'b1;
          end
        end else begin
          timer_d = timer_q - T_ONE;
        end
      end
      default: begin
        state_d = S_IDLE;
        sh_d    = '0;
        timer_d = T_ZERO;
        bits_d  = L_ZERO;
        a_d     = 1'b0;
        b_d     = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      sh_q    <= '0;
      timer_q <= T_ZERO;
      bits_q  <= L_ZERO;
      a_q     <= 1'b0;
      b_q     <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      timer_q <= timer_d;
      bits_q  <= bits_d;
      a_q     <= a_d;
      b_q     <= b_d;
      done_q  <= done_d;
    end
  end

  assign a_out_o     = a_q;
  assign b_out_o     = b_q;
  assign ready_o     = (state_q == S_IDLE);
  assign busy_o      = (state_q != S_IDLE);
  assign done_o      = done_q;
  assign bits_left_o = bits_q;

endmodule

// File: tb/tb_ab_pulse_sender.sv
// Scoreboard bench for ab_pulse_sender: stimulus queues timed line events,
// a negedge monitor pops and compares every edge and done strobe it observes.
module tb_ab_pulse_sender;

  localparam int P  = 4;
  localparam int G  = 4;
  localparam int PG = P + G;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       start_i;
  logic [7:0] data_i;
  logic [3:0] len_i;
  logic       abort_i;
  logic       a_out_o, b_out_o, ready_o, busy_o, done_o;
  logic [3:0] bits_left_o;

  ab_pulse_sender #(.WIDTH(8), .LEN_W(4), .PULSE_LEN(P), .GAP_LEN(G)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .data_i(data_i),
    .len_i(len_i), .abort_i(abort_i), .a_out_o(a_out_o), .b_out_o(b_out_o),
    .ready_o(ready_o), .busy_o(busy_o), .done_o(done_o),
    .bits_left_o(bits_left_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct { byte kind; int cyc; } ev_t;
  ev_t sb[$];

  int   errs = 0;
  int   checks = 0;
  int   edge_cnt = 0;
  int   det_cnt = 0;
  logic [3:0] det_hist = 4'b0000;
  logic pa = 1'b0;
  logic pb = 1'b0;

  always @(posedge clk_i) edge_cnt++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_cnt);
    end
  endtask

  task automatic observe(input byte k);
    ev_t e;
    checks++;
    if (sb.size() == 0) begin
      errs++;
      $display("FAIL unexpected_event: got %c@%0d expected none", k, edge_cnt);
    end else begin
      e = sb.pop_front();
      if (e.kind != k || e.cyc != edge_cnt) begin
        errs++;
        $display("FAIL event: got %c@%0d expected %c@%0d", k, edge_cnt, e.kind, e.cyc);
      end
    end
  endtask

  // Monitor: converts line edges and done strobes into events for the scoreboard.
  always @(negedge clk_i) begin
    if (rst_i) begin
      pa = 1'b0;
      pb = 1'b0;
    end else begin
      checks++;
      if (a_out_o && b_out_o) begin
        errs++;
        $display("FAIL overlap: got a=1 b=1 expected never both at edge %0d", edge_cnt);
      end
      if (!a_out_o && pa) observe(8'h61);
      if (!b_out_o && pb) observe(8'h62);
      if (a_out_o && !pa) begin
        observe(8'h41);
        det_hist = {det_hist[2:0], 1'b1};
        det_cnt++;
      end
      if (b_out_o && !pb) begin
        observe(8'h42);
        det_hist = {det_hist[2:0], 1'b0};
        det_cnt++;
      end
      if (done_o) observe(8'h44);
      pa = a_out_o;
      pb = b_out_o;
    end
  end

  task automatic send(input logic [7:0] d, input logic [3:0] l, output int t0);
    int n;
    logic bitv;
    n = (l > 4'd8) ? 8 : int'(l);
    @(negedge clk_i);
    data_i = d; len_i = l; start_i = 1'b1;
    @(posedge clk_i);
    #1;
    start_i = 1'b0;
    t0 = edge_cnt;
    for (int k = 0; k < n; k++) begin
      bitv = d[n-1-k];
      sb.push_back('{bitv ? 8'h41 : 8'h42, t0 + k*PG});
      sb.push_back('{bitv ? 8'h61 : 8'h62, t0 + k*PG + P});
    end
    sb.push_back('{8'h44, t0 + n*PG});
  endtask

  task automatic wait_until(input int e);
    while (edge_cnt < e) @(negedge clk_i);
  endtask

  task automatic drain(input string name, input int budget);
    int n;
    n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge clk_i);
      n++;
    end
    chk({name, "_drain_left"}, sb.size(), 0);
    sb.delete();
    @(negedge clk_i);
    chk({name, "_ready"}, ready_o, 1'b1);
  endtask

  int t0;

  initial begin
    rst_i = 1'b1; start_i = 1'b0; abort_i = 1'b0; data_i = 8'h00; len_i = 4'd0;
    repeat (3) @(negedge clk_i);
    chk("rst_a", a_out_o, 1'b0);
    chk("rst_b", b_out_o, 1'b0);
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_done", done_o, 1'b0);
    chk("rst_bits", bits_left_o, 4'd0);
    chk("rst_ready", ready_o, 1'b1);
    #2 rst_i = 1'b0;

    // Full byte: A,B,A,A,B,B,A,B, done at cycle 65.
    send(8'b1011_0010, 4'd8, t0);
    wait_until(t0 + 1);
    chk("main_busy", busy_o, 1'b1);
    chk("main_ready", ready_o, 1'b0);
    drain("main", 100);

    // Same word with a stray start and changed data/len mid-transfer.
    send(8'b1011_0010, 4'd8, t0);
    wait_until(t0 + 9);
    start_i = 1'b1; data_i = 8'h00; len_i = 4'd1;
    @(negedge clk_i);
    start_i = 1'b0;
    drain("ignore_start", 100);

    // Zero-length request: done next cycle, no pulses.
    send(8'hFF, 4'd0, t0);
    @(negedge clk_i);
    chk("len0_ready", ready_o, 1'b1);
    chk("len0_busy", busy_o, 1'b0);
    drain("len0", 10);

    // len above WIDTH clamps to 8 bits.
    send(8'b1000_0001, 4'd12, t0);
    drain("clamp", 100);

    // Abort sampled at the end of cycle 6.
    send(8'hA5, 4'd8, t0);
    wait_until(t0 + 5);
    abort_i = 1'b1;
    @(negedge clk_i);
    abort_i = 1'b0;
    chk("abort_a", a_out_o, 1'b0);
    chk("abort_b", b_out_o, 1'b0);
    chk("abort_ready", ready_o, 1'b1);
    chk("abort_bits", bits_left_o, 4'd0);
    wait_until(t0 + 30);
    chk("abort_no_more_events", sb.size(), 15);
    sb.delete();

    // Fresh start after abort; bits_left walks 3,2,1,0.
    send(8'hF5, 4'd3, t0);
    wait_until(t0 + 1);
    chk("len3_bits3", bits_left_o, 4'd3);
    wait_until(t0 + 9);
    chk("len3_bits2", bits_left_o, 4'd2);
    wait_until(t0 + 17);
    chk("len3_bits1", bits_left_o, 4'd1);
    drain("len3", 40);
    chk("len3_bits0", bits_left_o, 4'd0);

    // Asynchronous reset in the middle of a pulse.
    send(8'hFF, 4'd8, t0);
    wait_until(t0 + 1);
    #2 rst_i = 1'b1;
    #1;
    chk("arst_a", a_out_o, 1'b0);
    chk("arst_b", b_out_o, 1'b0);
    @(negedge clk_i);
    sb.delete();
    #2 rst_i = 1'b0;
    chk("arst_ready", ready_o, 1'b1);
    chk("arst_bits", bits_left_o, 4'd0);
    send(8'b0000_0010, 4'd2, t0);
    drain("after_rst", 40);

    // Loopback into a 1011 sequence detector model.
    det_cnt = 0;
    det_hist = 4'b0000;
    send(8'b0000_1011, 4'd4, t0);
    wait_until(t0 + 22);
    chk("loop_det_before", (det_cnt >= 4 && det_hist == 4'b1011), 1'b0);
    wait_until(t0 + 26);
    chk("loop_det_after", (det_cnt >= 4 && det_hist == 4'b1011), 1'b1);
    drain("loop", 40);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/ab_pulse_sender.md
Name: ab_pulse_sender

Overview:
- Transmit-side counterpart of the A/B button-pulse sequence detector.
- Accepts a parallel word and serialises it MSB-first onto two pulse lines: a '1' bit is a pulse on a_out, a '0' bit is a pulse on b_out.
- Each pulse is followed by an idle gap, so a downstream rising-edge (press) detector sees exactly one event per bit.
- Used as an on-board stimulus source or for loopback driving of the detector's A/B inputs.

Parameters:
- WIDTH, 8: maximum bits per transfer.
- LEN_W, 4: width of len port; must hold WIDTH.
- PULSE_LEN, 4: clock cycles a_out/b_out stays high per bit; ≥1.
- GAP_LEN, 4: clock cycles both lines stay low after each pulse; ≥1.

Ports:
- clk  in  1  single system clock; all logic on posedge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request to send; accepted only when ready=1.
- data  in  WIDTH  word to send, bit len-1 first, down to bit 0.
- len  in  LEN_W  number of bits to send, 0..WIDTH; values above WIDTH are clamped to WIDTH.
- abort  in  1  synchronous cancel of an in-progress transfer.
- a_out  out  1  pulse line for '1' bits (registered).
- b_out  out  1  pulse line for '0' bits (registered).
- ready  out  1  high in IDLE; start is accepted.
- busy  out  1  high in PULSE or GAP.
- done  out  1  one-cycle strobe when a transfer completes normally.
- bits_left  out  LEN_W  bits not yet fully sent, including the current bit.

Behaviour:
- Reset, asynchronous:
  - state=IDLE.
  - a_out=0, b_out=0, busy=0, done=0, bits_left=0.
  - ready=1.
  - Internal shift register and timers are cleared.
  - A reset mid-transfer drops the lines immediately, with no done strobe.
- States:
  - IDLE: ready=1. When start=1 is sampled at an edge:
    - data and clamped len are latched.
    - If len≠0: go to PULSE and assert the line for bit len-1 at the same edge.
    - If len=0: stay IDLE and pulse done for the next cycle.
  - PULSE: the selected line stays high for exactly PULSE_LEN cycles, then → GAP with both lines low.
  - GAP: both lines stay low for exactly GAP_LEN cycles. At the end of the last gap cycle:
    - If bits_left>1: decrement bits_left and → PULSE with the next bit.
    - Otherwise: → IDLE, with done=1 for one cycle and bits_left=0.
- Latency:
  - With start sampled at edge 0, the first pulse is high during cycles 1..PULSE_LEN.
  - Bit k (k=0 first) occupies cycles 1+k·(P+G) .. (k+1)·(P+G).
  - done is high in cycle len·(P+G)+1, the same cycle ready returns to 1.
- Line rules:
  - a_out and b_out are never high together.
  - Each line has exactly one rising edge per bit.
  - Lines are glitch-free (driven directly from flops).
- Handshake:
  - start while busy is ignored. No queuing; data and len changes during a transfer have no effect.
  - start in the done cycle is accepted because ready=1.
- abort:
  - Sampled at an edge in PULSE or GAP: next cycle both lines are low, state=IDLE, bits_left=0, and done is not asserted.
  - abort in IDLE has no effect.
  - abort and start in the same IDLE cycle: start wins.
- Counters: bits_left is loaded with the clamped len. Pulse and gap timers are sized for max(PULSE_LEN, GAP_LEN) and do not wrap.

Test Plan:
- Reset, P=4, G=4, start with data=8'b1011_0010, len=8 →
  - a_out high in cycles 1–4, 17–20, 25–32 region per bit order.
  - Line sequence A,B,A,A,B,B,A,B.
  - done in cycle 65.
  - Both lines never high together.
- len=3, data=8'bxxxx_x101 → pulse order A,B,A; done in cycle 25; bits_left steps 3,2,1,0.
- len=0 with start → no pulses, done=1 in cycle 1, ready stays 1.
- start pulsed during a transfer (cycle 10) → ignored; output stream identical to the unperturbed case.
- abort asserted in cycle 6 of a len=8 transfer → both lines low from cycle 7, ready=1, no done. A new start is then accepted normally.
- Asynchronous rst raised mid-pulse (between edges) → a_out/b_out fall immediately. After release, a fresh len=2, data=2'b10 transfer gives A then B and done in cycle 17.
- Loopback: a_out/b_out drive the detector's A/B inputs with data=4'b1011 → detector reaches its output-high state after the 4th pulse.
